// File: rtl/seal_line_pkg.sv
// Shared definitions for the sealing line: arbiter state encodings,
// status counter width and default timing constants.
package seal_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_GRANT   = 3'b001,
    ST_SEAL    = 3'b010,
    ST_RELEASE = 3'b011,
    ST_FAULT   = 3'b100
  } state_t;

  localparam int SEAL_COUNT_W    = 16;
  localparam int DEF_N_LANES     = 4;
  localparam int DEF_SEAL_CYCLES = 3;
  localparam int DEF_ACK_TIMEOUT = 8;

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // One timer serves both the ack wait and the seal hold, so size it for the longer.
  function automatic int timer_width(input int seal_cycles, input int ack_timeout);
    return $clog2(max2(seal_cycles, ack_timeout)) + 1;
  endfunction

endpackage

// File: rtl/seal_station_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first requester after the
// pointer position, wrapping modulo N_LANES. Kept generic for reuse.
module rr_select #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [LANE_W-1:0]  ptr,
  output logic [N_LANES-1:0] onehot,
  output logic [LANE_W-1:0]  idx,
  output logic               valid
);

  // Scan ptr+1 .. ptr+N_LANES (wrapped); the first hit wins, later hits are masked.
  always_comb begin
    int                lane_v;
    logic [LANE_W-1:0] lane_s;
    logic              hit_s;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    lane_v = 0;
    lane_s = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= N_LANES; i++) begin
      lane_v         = int'(ptr) + i;
      lane_v         = (lane_v >= N_LANES) ? (lane_v - N_LANES) : lane_v;
      lane_s         = LANE_W'(lane_v);
      hit_s          = !valid && req[lane_s];
      onehot[lane_s] = onehot[lane_s] | hit_s;
      idx            = hit_s ? lane_s : idx;
      valid          = valid | hit_s;
    end
  end

endmodule

// File: rtl/seal_station_arbiter.sv
// Sealing-head arbiter: grants one filling lane at a time (round-robin),
// waits for bottle-positioned ack, drives the sealer for a fixed time,
// and reports completion, ack timeouts and a saturating seal count.
module seal_station_arbiter
  import seal_line_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int SEAL_CYCLES = DEF_SEAL_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int LANE_W      = $clog2(N_LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_LANES-1:0]      req,
  input  logic [N_LANES-1:0]      ack,
  output logic [N_LANES-1:0]      gnt,
  output logic                    seal_on,
  output logic [N_LANES-1:0]      done,
  output logic                    fault,
  output logic [LANE_W-1:0]       fault_lane,
  output logic                    busy,
  output logic [2:0]              state_indicator,
  output logic [SEAL_COUNT_W-1:0] seal_count
);

  localparam int                      TIMER_W   = timer_width(SEAL_CYCLES, ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0]      ACK_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]      SEAL_LAST = TIMER_W'(SEAL_CYCLES - 1);
  localparam logic [LANE_W-1:0]       PTR_RESET = LANE_W'(N_LANES - 1);
  localparam logic [SEAL_COUNT_W-1:0] COUNT_MAX = {SEAL_COUNT_W{1'b1}};

  state_t                  state_q,      state_d;
  logic [N_LANES-1:0]      gnt_q,        gnt_d;
  logic                    seal_on_q,    seal_on_d;
  logic [N_LANES-1:0]      done_q,       done_d;
  logic                    fault_q,      fault_d;
  logic [LANE_W-1:0]       fault_lane_q, fault_lane_d;
  logic                    busy_q,       busy_d;
  logic [SEAL_COUNT_W-1:0] seal_count_q, seal_count_d;
  logic [TIMER_W-1:0]      timer_q,      timer_d;
  logic [LANE_W-1:0]       sel_q,        sel_d;
  logic [LANE_W-1:0]       rr_ptr_q,     rr_ptr_d;

  logic [N_LANES-1:0]      pick_onehot_s;
  logic [LANE_W-1:0]       pick_idx_s;
  logic                    pick_valid_s;
  logic [N_LANES-1:0]      sel_onehot_s;

  rr_select #(
    .N_LANES (N_LANES),
    .LANE_W  (LANE_W)
  ) u_rr_select (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // One-hot form of the latched lane, used for the done pulse.
  always_comb begin
    sel_onehot_s        = '0;
    sel_onehot_s[sel_q] = 1'b1;
  end

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    seal_on_d    = seal_on_q;
    done_d       = '0;
    fault_d      = 1'b0;
    fault_lane_d = fault_lane_q;
    seal_count_d = seal_count_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        // en only matters here; an accepted transaction always runs to the end.
        if (en && pick_valid_s) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot_s;
          sel_d   = pick_idx_s;
          timer_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Ack wins over a simultaneous timeout; other lanes' acks are not looked at.
        if (ack[sel_q]) begin
          state_d   = ST_SEAL;
          seal_on_d = 1'b1;
          timer_d   = '0;
        end else if (!req[sel_q]) begin
          // Lane withdrew: back off silently and keep its priority position.
          state_d = ST_IDLE;
          gnt_d   = '0;
          timer_d = '0;
        end else if (timer_q == ACK_LAST) begin
          state_d      = ST_FAULT;
          gnt_d        = '0;
          fault_d      = 1'b1;
          fault_lane_d = sel_q;
          rr_ptr_d     = sel_q;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_SEAL: begin
        // The seal is never cut short once the actuator is on.
        if (timer_q == SEAL_LAST) begin
          state_d      = ST_RELEASE;
          seal_on_d    = 1'b0;
          gnt_d        = '0;
          done_d       = sel_onehot_s;
          rr_ptr_d     = sel_q;
          seal_count_d = (seal_count_q == COUNT_MAX) ? seal_count_q
                                                     : seal_count_q + SEAL_COUNT_W'(1);
          timer_d      = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        seal_on_d = 1'b0;
        timer_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      seal_on_q    <= 1'b0;
      done_q       <= '0;
      fault_q      <= 1'b0;
      fault_lane_q <= '0;
      busy_q       <= 1'b0;
      seal_count_q <= '0;
      timer_q      <= '0;
      sel_q        <= '0;
      rr_ptr_q     <= PTR_RESET;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      seal_on_q    <= seal_on_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_lane_q <= fault_lane_d;
      busy_q       <= busy_d;
      seal_count_q <= seal_count_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign gnt             = gnt_q;
  assign seal_on         = seal_on_q;
  assign done            = done_q;
  assign fault           = fault_q;
  assign fault_lane      = fault_lane_q;
  assign busy            = busy_q;
  assign state_indicator = state_q;
  assign seal_count      = seal_count_q;

endmodule

// File: tb/tb_seal_station_arbiter.sv
// Self-checking bench for seal_station_arbiter (4 lanes, 3-cycle seal,
// 8-cycle ack timeout). Expected done/fault events go into a scoreboard
// queue at grant time and are matched when the pulses appear.
module tb_seal_station_arbiter;

  localparam int SEAL_CYCLES = 3;
  localparam int ACK_TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        seal_on;
  logic [3:0]  done;
  logic        fault;
  logic [1:0]  fault_lane;
  logic        busy;
  logic [2:0]  state_indicator;
  logic [15:0] seal_count;

  int tests = 0;
  int fails = 0;
  int flag;

  typedef struct {
    bit is_fault;
    int lane;
  } ev_t;

  typedef struct {
    logic [3:0] req;
    int         ack_dly;
    int         lane;
    bit         is_fault;
    int         count;
  } vec_t;

  ev_t        sb_q[$];
  ev_t        mon_e;
  logic [3:0] mon_oh;
  logic [4:0] mon_exp;
  vec_t       vecs[12];

  seal_station_arbiter #(
    .N_LANES     (4),
    .SEAL_CYCLES (SEAL_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .LANE_W      (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .req             (req),
    .ack             (ack),
    .gnt             (gnt),
    .seal_on         (seal_on),
    .done            (done),
    .fault           (fault),
    .fault_lane      (fault_lane),
    .busy            (busy),
    .state_indicator (state_indicator),
    .seal_count      (seal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard matching of done/fault pulses plus per-cycle output invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (done != 4'b0000 || fault) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'({fault, done}), 32'd0);
        end else begin
          mon_e   = sb_q.pop_front();
          mon_oh  = 4'b0001 << mon_e.lane;
          mon_exp = mon_e.is_fault ? 5'b10000 : {1'b0, mon_oh};
          check("pulse_fault_done", 32'({fault, done}), 32'(mon_exp));
          if (mon_e.is_fault) begin
            check("fault_lane", 32'(fault_lane), 32'(mon_e.lane));
          end
        end
      end
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("gnt_state", 32'(gnt == 4'b0000 || state_indicator == 3'd1 || state_indicator == 3'd2), 32'd1);
      check("seal_state", 32'(!seal_on || state_indicator == 3'd2), 32'd1);
      check("busy_state", 32'(busy), 32'(state_indicator != 3'd0));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b0000;
    ack = 4'b0000;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (state_indicator != 3'b000 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(state_indicator), 32'd0);
  endtask

  // Drive a request pattern from IDLE and expect a grant to `lane` one cycle later.
  task automatic grant(input logic [3:0] r, input int lane);
    int n;
    n   = 0;
    req = r;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0000 && n < 20);
    check("gnt_latency", n, 1);
    check("gnt_lane", 32'(gnt), 32'(4'b0001 << lane));
  endtask

  // Ack the granted lane and count seal_on cycles; action 1 drops req, 2 drops en mid-seal.
  task automatic do_seal(input int lane, input int action);
    int n;
    n   = 0;
    ack = 4'b0001 << lane;
    @(negedge clk);
    while (seal_on && n < 20) begin
      n++;
      if (n == 1) begin
        ack = 4'b0000;
        if (action == 1) req = 4'b0000;
        if (action == 2) en = 1'b0;
      end
      @(negedge clk);
    end
    ack = 4'b0000;
    check("seal_cycles", n, SEAL_CYCLES);
  endtask

  task automatic txn(input logic [3:0] r, input int dly, input int lane, input bit is_fault);
    int n;
    grant(r, lane);
    sb_q.push_back('{is_fault, lane});
    if (is_fault) begin
      n = 0;
      while (gnt == (4'b0001 << lane) && n < 20) begin
        n++;
        @(negedge clk);
      end
      check("gnt_hold_timeout", n, ACK_TIMEOUT);
    end else begin
      repeat (dly) @(negedge clk);
      do_seal(lane, 0);
    end
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_seal_on", 32'(seal_on), 32'd0);
    check("rst_done_fault", 32'({fault, done}), 32'd0);
    check("rst_fault_lane", 32'(fault_lane), 32'd0);
    check("rst_count", 32'(seal_count), 32'd0);
    check("rst_state_busy", 32'({busy, state_indicator}), 32'd0);

    // Single lane, ack two cycles after grant.
    txn(4'b0001, 2, 0, 1'b0);
    check("single_count", 32'(seal_count), 32'd1);

    // Round-robin / timeout table, starting from reset priority.
    do_reset();
    vecs[0]  = '{4'b1111, 0, 0, 1'b0, 1};
    vecs[1]  = '{4'b1111, 0, 1, 1'b0, 2};
    vecs[2]  = '{4'b1111, 0, 2, 1'b0, 3};
    vecs[3]  = '{4'b1111, 0, 3, 1'b0, 4};
    vecs[4]  = '{4'b1111, 0, 0, 1'b0, 5};
    vecs[5]  = '{4'b0100, 0, 2, 1'b1, 5};
    vecs[6]  = '{4'b1111, 0, 3, 1'b0, 6};
    vecs[7]  = '{4'b0011, 1, 0, 1'b0, 7};
    vecs[8]  = '{4'b0011, 0, 1, 1'b0, 8};
    vecs[9]  = '{4'b1010, 3, 3, 1'b0, 9};
    vecs[10] = '{4'b1010, 0, 1, 1'b0, 10};
    vecs[11] = '{4'b0001, 0, 0, 1'b0, 11};
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].req, vecs[i].ack_dly, vecs[i].lane, vecs[i].is_fault);
      check("table_count", 32'(seal_count), 32'(vecs[i].count));
    end
    check("fault_lane_sticky", 32'(fault_lane), 32'd2);

    // Abort in GRANT: no pulse, pointer unchanged so lane 1 wins again.
    grant(4'b0010, 1);
    req = 4'b0000;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_state", 32'(state_indicator), 32'd0);
    repeat (3) @(negedge clk);
    txn(4'b0011, 0, 1, 1'b0);

    // Foreign ack ignored, then req dropped during SEAL still completes.
    grant(4'b0001, 0);
    sb_q.push_back('{1'b0, 0});
    ack  = 4'b1000;
    flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (seal_on || gnt != 4'b0001) flag = 1;
    end
    check("foreign_ack_ignored", flag, 0);
    do_seal(0, 1);
    wait_idle();

    // Enable low blocks grants; dropping en mid-seal lets the seal finish.
    en   = 1'b0;
    req  = 4'b1111;
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != 4'b0000 || busy) flag = 1;
    end
    check("en_low_no_grant", flag, 0);
    en = 1'b1;
    grant(4'b1111, 1);
    sb_q.push_back('{1'b0, 1});
    do_seal(1, 2);
    wait_idle();
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != 4'b0000 || busy) flag = 1;
    end
    check("en_drop_no_regrant", flag, 0);
    check("count_before_rst", 32'(seal_count), 32'd14);

    // Asynchronous reset in the middle of a seal, away from any clock edge.
    en = 1'b1;
    grant(4'b0100, 2);
    ack = 4'b0100;
    @(negedge clk);
    check("seal_on_before_rst", 32'(seal_on), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_seal_on", 32'(seal_on), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_count", 32'(seal_count), 32'd0);
    check("arst_state", 32'(state_indicator), 32'd0);
    ack = 4'b0000;
    req = 4'b0000;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Saturation: preload the counter just below full.
    force dut.seal_count_q = 16'hFFFE;
    #1 release dut.seal_count_q;
    txn(4'b0001, 0, 0, 1'b0);
    check("count_reach_max", 32'(seal_count), 32'h0000FFFF);
    txn(4'b0010, 0, 1, 1'b0);
    check("count_saturated", 32'(seal_count), 32'h0000FFFF);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seal_station_arbiter.md
Name: seal_station_arbiter

Overview:
Shares one sealing head among N filling lanes. Each lane raises a request when it holds a filled bottle. The arbiter grants the head round-robin, waits for the lane to confirm the bottle is positioned, then drives the seal actuator for a fixed time and reports completion. It sits between the per-lane fill/seal FSMs and the physical sealer, and adds timeout fault handling and a seal counter for the line status display.

Parameters:
N_LANES, 4, number of requesting filling lanes (2..8)
SEAL_CYCLES, 3, clock cycles seal_on stays high per bottle (>=1)
ACK_TIMEOUT, 8, max cycles in GRANT waiting for ack before fault (>=1)
LANE_W, $clog2(N_LANES), width of lane index

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  arbitration enable; low = no new grants
req  in  N_LANES  per-lane level request, bottle filled and waiting
ack  in  N_LANES  per-lane bottle-positioned confirmation
gnt  out  N_LANES  one-hot grant, registered
seal_on  out  1  seal actuator drive, registered
done  out  N_LANES  one-cycle pulse to the lane just sealed
fault  out  1  one-cycle pulse on ack timeout
fault_lane  out  LANE_W  index of last timed-out lane, sticky
busy  out  1  high in any state other than IDLE
state_indicator  out  3  current state encoding
seal_count  out  16  completed seals, saturating

Behaviour:
- Reset (async) values: state=IDLE, gnt=0, seal_on=0, done=0, fault=0, fault_lane=0, seal_count=0, timer=0. rr_ptr=N_LANES-1, so lane 0 has first priority.
- States and encodings: IDLE=000, GRANT=001, SEAL=010, RELEASE=011, FAULT=100. Unused codes go to IDLE.
- IDLE: if en and |req, select the first requesting lane scanning from rr_ptr+1, modulo N_LANES. Next cycle: state=GRANT, gnt=onehot(sel), sel latched, timer cleared. Latency from req to gnt is 1 cycle.
- GRANT:
  - ack[sel]=1: go to SEAL, seal_on=1, timer cleared.
  - req[sel] drops before ack: abort to IDLE, gnt=0, no done, no fault, rr_ptr unchanged.
  - timer reaches ACK_TIMEOUT-1 with no ack: go to FAULT.
  - ack is priority over timeout when both occur in the same cycle.
  - ack from non-granted lanes is ignored.
- SEAL: seal_on held high for exactly SEAL_CYCLES cycles, gnt held. req/ack changes are ignored; the seal always completes. Then go to RELEASE.
- RELEASE (1 cycle): seal_on=0, gnt=0, done[sel]=1, rr_ptr=sel, seal_count+1 saturating at 16'hFFFF. Then go to IDLE.
- FAULT (1 cycle): gnt=0, fault=1, fault_lane=sel, rr_ptr=sel so the faulty lane loses priority. Then go to IDLE.
- en deasserted mid-operation does not abort; the current transaction completes. en is sampled only in IDLE.
- Minimum spacing between consecutive grants: IDLE occupies 1 cycle between transactions.
- gnt and seal_on are never high outside GRANT/SEAL. gnt is always one-hot or zero.
- Timer width: $clog2(max(SEAL_CYCLES, ACK_TIMEOUT))+1.
- state_indicator equals the state register.

Decomposition:
- Shared package seal_line_pkg: state encodings (IDLE..FAULT), SEAL_COUNT_W=16, default timing constants.
- One sub-module, rr_select: combinational round-robin pick. Inputs: req vector and pointer. Outputs: onehot, index, valid. Reusable for future filler-valve sharing.

Test Plan:
- Single lane: req=4'b0001 at reset release, ack after 2 cycles -> gnt=0001 in the cycle after req; seal_on high exactly 3 cycles; done[0] one pulse; seal_count=1.
- All lanes: req=4'b1111 held, immediate acks -> grant order 0,1,2,3,0; no lane granted twice before every other lane is served.
- Timeout: req=4'b0100, no ack -> gnt=0100 for 8 cycles, then fault=1 for 1 cycle, fault_lane=2, no done, seal_count unchanged; next grant goes to lane 3 if requesting.
- Aborts and ignored events: drop req[1] during GRANT -> gnt to 0 next cycle, no fault, no done. Drop req during SEAL -> seal completes, done pulses. ack[3] while lane 0 is granted -> ignored.
- Enable and reset: en=0 with req=1111 -> no grant. en falling during SEAL -> transaction completes, then no further grants. Async rst mid-SEAL -> seal_on, gnt, and count clear immediately, without waiting for a clock edge.
- Saturation: preload via 65535 fast seals (or force) -> seal_count stays at 16'hFFFF after the next seal.
